// File: rtl/pn_gen_param.sv
// Parametrised Fibonacci-LFSR PN generator: PAR steps per enabled clock, runtime seed load, zero-lock protection.
// Optional error injection on y/dout[0] when PN_GEN_ERRINJ_EN is defined (adds input err_inj).

module pn_gen_step #(
  parameter int                 WIDTH = 4,
  parameter logic [WIDTH-1:0]   TAPS  = 4'b1001
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);
  logic fb;

  assign fb  = ^(cur & TAPS);
  assign nxt = {fb, cur[WIDTH-1:1]};
endmodule

module pn_gen_param #(
  parameter int                 WIDTH = 4,
  parameter logic [WIDTH-1:0]   TAPS  = 4'b1001,
  parameter logic [WIDTH-1:0]   SEED  = 4'b1111,
  parameter int                 PAR   = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
`ifdef PN_GEN_ERRINJ_EN
  input  logic             err_inj,
`endif
  output logic             y,
  output logic [PAR-1:0]   dout,
  output logic [WIDTH-1:0] state,
  output logic             sof,
  output logic             lockfix
);
  logic [WIDTH-1:0]          d;
  logic [PAR:0][WIDTH-1:0]   chain;
  logic [PAR-1:0]            look;
  logic [WIDTH-1:0]          stepped;

  // chain[k] is d advanced by k single steps; chain[PAR] is the next state.
  assign chain[0] = d;

  for (genvar k = 0; k < PAR; k++) begin : g_step
    pn_gen_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
      .cur (chain[k]),
      .nxt (chain[k+1])
    );
    assign look[k] = chain[k][0];
  end

  // Degenerate taps (no TAPS[0]) can collapse to zero; fall back to SEED so the generator never stalls.
  assign stepped = (chain[PAR] == '0) ? SEED : chain[PAR];

  always_ff @(posedge clk) begin
    if (res) begin
      d       <= SEED;
      lockfix <= 1'b0;
    end else if (load) begin
      if (seed_in == '0) begin
        d       <= SEED;
        lockfix <= 1'b1;
      end else begin
        d       <= seed_in;
        lockfix <= 1'b0;
      end
    end else begin
      lockfix <= 1'b0;
      if (en) d <= stepped;
    end
  end

  assign state = d;
  assign sof   = (d == SEED);

`ifdef PN_GEN_ERRINJ_EN
  assign y = d[0] ^ err_inj;
  always_comb begin
    dout    = look;
    dout[0] = look[0] ^ err_inj;
  end
`else
  assign y    = d[0];
  assign dout = look;
`endif
endmodule
